ift_taint_monitor: RTL and testbench

- Response-side counterpart to the flip-flop IFT stimulus benches.
- Samples a DUT's data output Q and its taint vector Q_t every clock during a capture window.
- Detects taint-propagation events and logs timestamped records into an internal FIFO, drained through a valid/ready read port.
- Sits beside any m_0 IFT DUT, in a bench or on-chip harness, in place of post-processing the VCD dump.

---
 rtl/ift_taint_monitor.sv | 127 ++++++++++++
 tb/tb_ift_taint_monitor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ift_taint_monitor.sv
// ift_taint_monitor: samples Q/Q_t during a capture window, logs taint-propagation events into a record FIFO
// Ports: CLK, RST_N (sync, active-low); START/STOP/WINDOW control the window; Q/Q_t are the monitored DUT outputs;
// REC_VALID/REC_READY/REC_DATA form the record read port ({ts, Q, Q_t}); BUSY/DONE decode state;
// EVT_CNT/OVF_CNT count detected and dropped events. Define IFT_MONITOR_STICKY_EN to add STICKY_T (taint union).
module ift_taint_monitor #(
  parameter int DW    = 2,
  parameter int TW    = 32,
  parameter int DEPTH = 8,
  parameter int TSW   = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 STOP,
  input  logic [TSW-1:0]       WINDOW,
  input  logic [DW-1:0]        Q,
  input  logic [TW-1:0]        Q_t,
  output logic                 REC_VALID,
  input  logic                 REC_READY,
  output logic [TSW+DW+TW-1:0] REC_DATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [15:0]          EVT_CNT,
`ifdef IFT_MONITOR_STICKY_EN
  output logic [TW-1:0]        STICKY_T,
`endif
  output logic [7:0]           OVF_CNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = TSW + DW + TW;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] prev_q_q, prev_q_d;
  logic [TW-1:0] prev_t_q, prev_t_d;
  logic [TSW-1:0] ts_q, ts_d;
  logic [15:0] evt_q, evt_d;
  logic [7:0] ovf_q, ovf_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [RW-1:0] mem [DEPTH];
  logic run, start_ok, evt, term, full, pop, push;
`ifdef IFT_MONITOR_STICKY_EN
  logic [TW-1:0] sticky_q, sticky_d;
  assign STICKY_T = sticky_q;
`endif
  assign run      = state_q == RUN;
  assign start_ok = START && !run;
  assign evt      = run && ((Q_t != prev_t_q) || ((Q_t != '0) && (Q != prev_q_q)));
  assign term     = STOP || ((WINDOW != '0) && (ts_q == WINDOW - TSW'(1)));
  assign full     = cnt_q == (AW+1)'(DEPTH);
  assign pop      = (cnt_q != '0) && REC_READY;
  // a pop frees the slot in the same cycle, so a full FIFO still accepts
  assign push     = evt && (!full || pop);
  assign REC_VALID = cnt_q != '0;
  assign REC_DATA  = REC_VALID ? mem[rd_q] : '0;
  assign BUSY      = run;
  assign DONE      = state_q == FIN;
  assign EVT_CNT   = evt_q;
  assign OVF_CNT   = ovf_q;
  always_comb begin
    state_d  = state_q;
    prev_q_d = prev_q_q;
    prev_t_d = prev_t_q;
    ts_d     = ts_q;
    evt_d    = evt_q;
    ovf_d    = ovf_q;
`ifdef IFT_MONITOR_STICKY_EN
    sticky_d = sticky_q;
`endif
    wr_d     = push ? wr_q + AW'(1) : wr_q;
    rd_d     = pop ? rd_q + AW'(1) : rd_q;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    if (start_ok) begin
      state_d  = RUN;
      prev_q_d = Q;
      prev_t_d = Q_t;
      ts_d     = '0;
      evt_d    = '0;
      ovf_d    = '0;
`ifdef IFT_MONITOR_STICKY_EN
      sticky_d = '0;
`endif
    end else if (run) begin
      state_d  = term ? FIN : RUN;
      prev_q_d = Q;
      prev_t_d = Q_t;
      ts_d     = ts_q + TSW'(ts_q != '1);
      evt_d    = evt_q + 16'(evt && evt_q != 16'hFFFF);
      ovf_d    = ovf_q + 8'(evt && !push && ovf_q != 8'hFF);
`ifdef IFT_MONITOR_STICKY_EN
      sticky_d = sticky_q | Q_t;
`endif
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      prev_q_q <= '0;
      prev_t_q <= '0;
      ts_q     <= '0;
      evt_q    <= '0;
      ovf_q    <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
`ifdef IFT_MONITOR_STICKY_EN
      sticky_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      prev_q_q <= prev_q_d;
      prev_t_q <= prev_t_d;
      ts_q     <= ts_d;
      evt_q    <= evt_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
`ifdef IFT_MONITOR_STICKY_EN
      sticky_q <= sticky_d;
`endif
    end
  end
  always_ff @(posedge CLK) begin
    if (RST_N && push) mem[wr_q] <= {ts_q, Q, Q_t};
  end
endmodule

// File: tb/tb_ift_taint_monitor.sv
// tb_ift_taint_monitor: directed checks of capture, drain, overflow, restart and reset of ift_taint_monitor
module tb_ift_taint_monitor;
  logic        CLK = 1'b0;
  logic        RST_N, START, STOP, REC_READY, REC_VALID, BUSY, DONE;
  logic [15:0] WINDOW, EVT_CNT;
  logic [1:0]  Q;
  logic [31:0] Q_t;
  logic [49:0] REC_DATA;
  logic [7:0]  OVF_CNT;
`ifdef IFT_MONITOR_STICKY_EN
  logic [31:0] STICKY_T;
`endif
  int total = 0;
  int bad = 0;
  ift_taint_monitor dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .WINDOW(WINDOW),
    .Q(Q), .Q_t(Q_t), .REC_VALID(REC_VALID), .REC_READY(REC_READY), .REC_DATA(REC_DATA),
    .BUSY(BUSY), .DONE(DONE), .EVT_CNT(EVT_CNT),
`ifdef IFT_MONITOR_STICKY_EN
    .STICKY_T(STICKY_T),
`endif
    .OVF_CNT(OVF_CNT)
  );
  always #5 CLK = ~CLK;
  function automatic logic [49:0] rec(input logic [15:0] ts, input logic [1:0] q, input logic [31:0] qt);
    return {ts, q, qt};
  endfunction
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset();
    RST_N = 0; START = 0; STOP = 0; REC_READY = 0; WINDOW = 0; Q = 2'b11; Q_t = 32'hFFFFFFFF;
    tick(); tick();
    total++; if (REC_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", REC_VALID); end
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin bad++; $display("FAIL reset_state got busy=%b done=%b exp=0/0", BUSY, DONE); end
    total++; if (EVT_CNT !== 16'd0 || OVF_CNT !== 8'd0) begin bad++; $display("FAIL reset_cnt got evt=%0d ovf=%0d exp=0/0", EVT_CNT, OVF_CNT); end
    total++; if (REC_DATA !== 50'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", REC_DATA); end
    RST_N = 1; Q = 0; Q_t = 0;
    tick();
  endtask
  task automatic test_basic();
    WINDOW = 16'd10; Q = 0; Q_t = 0; START = 1;
    tick();
    START = 0;
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", BUSY); end
    for (int t = 0; t < 10; t++) begin
      Q_t = (t >= 3) ? 32'h1 : 32'h0;
      Q = (t >= 6) ? 2'b10 : (t >= 3) ? 2'b01 : 2'b00;
      if (t == 9) begin
        total++; if (BUSY !== 1'b1 || DONE !== 1'b0) begin bad++; $display("FAIL basic_run_ts9 got busy=%b done=%b exp=1/0", BUSY, DONE); end
      end
      tick();
    end
    total++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin bad++; $display("FAIL basic_done got done=%b busy=%b exp=1/0", DONE, BUSY); end
    total++; if (EVT_CNT !== 16'd2) begin bad++; $display("FAIL basic_evt got=%0d exp=2", EVT_CNT); end
    total++; if (REC_VALID !== 1'b1 || REC_DATA !== rec(16'd3, 2'b01, 32'h1)) begin bad++; $display("FAIL basic_rec0 got v=%b d=%h exp=1/%h", REC_VALID, REC_DATA, rec(16'd3, 2'b01, 32'h1)); end
    tick();
    total++; if (REC_DATA !== rec(16'd3, 2'b01, 32'h1)) begin bad++; $display("FAIL basic_hold got=%h exp=%h", REC_DATA, rec(16'd3, 2'b01, 32'h1)); end
    REC_READY = 1;
    tick();
    total++; if (REC_VALID !== 1'b1 || REC_DATA !== rec(16'd6, 2'b10, 32'h1)) begin bad++; $display("FAIL basic_rec1 got v=%b d=%h exp=1/%h", REC_VALID, REC_DATA, rec(16'd6, 2'b10, 32'h1)); end
    tick();
    total++; if (REC_VALID !== 1'b0 || REC_DATA !== 50'd0) begin bad++; $display("FAIL basic_empty got v=%b d=%h exp=0/0", REC_VALID, REC_DATA); end
    tick();
    total++; if (REC_VALID !== 1'b0) begin bad++; $display("FAIL basic_ready_empty got=%b exp=0", REC_VALID); end
    REC_READY = 0;
  endtask
  task automatic test_overflow();
    WINDOW = 0; Q = 0; Q_t = 0; START = 1;
    tick();
    START = 0;
    total++; if (EVT_CNT !== 16'd0 || OVF_CNT !== 8'd0) begin bad++; $display("FAIL ovf_start_clear got evt=%0d ovf=%0d exp=0/0", EVT_CNT, OVF_CNT); end
    for (int i = 0; i < 12; i++) begin
      Q_t = (i % 2 == 0) ? 32'h1 : 32'h0;
      STOP = (i == 11);
      tick();
    end
    STOP = 0;
    total++; if (EVT_CNT !== 16'd12 || OVF_CNT !== 8'd4) begin bad++; $display("FAIL ovf_cnt got evt=%0d ovf=%0d exp=12/4", EVT_CNT, OVF_CNT); end
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL ovf_done got=%b exp=1", DONE); end
    REC_READY = 1;
    for (int k = 0; k < 8; k++) begin
      total++; if (REC_VALID !== 1'b1 || REC_DATA !== rec(16'(k), 2'b00, (k % 2 == 0) ? 32'h1 : 32'h0)) begin bad++; $display("FAIL ovf_rec%0d got v=%b d=%h exp=1/%h", k, REC_VALID, REC_DATA, rec(16'(k), 2'b00, (k % 2 == 0) ? 32'h1 : 32'h0)); end
      tick();
    end
    total++; if (REC_VALID !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", REC_VALID); end
    REC_READY = 0;
  endtask
  task automatic test_full_pop();
    WINDOW = 0; Q = 0; Q_t = 0; START = 1;
    tick();
    START = 0;
    for (int i = 0; i < 9; i++) begin
      Q_t = (i % 2 == 0) ? 32'h1 : 32'h0;
      REC_READY = (i == 8);
      STOP = (i == 8);
      tick();
    end
    REC_READY = 0; STOP = 0;
    total++; if (EVT_CNT !== 16'd9 || OVF_CNT !== 8'd0) begin bad++; $display("FAIL fullpop_cnt got evt=%0d ovf=%0d exp=9/0", EVT_CNT, OVF_CNT); end
    REC_READY = 1;
    for (int k = 1; k < 9; k++) begin
      total++; if (REC_VALID !== 1'b1 || REC_DATA !== rec(16'(k), 2'b00, (k % 2 == 0) ? 32'h1 : 32'h0)) begin bad++; $display("FAIL fullpop_rec%0d got v=%b d=%h exp=1/%h", k, REC_VALID, REC_DATA, rec(16'(k), 2'b00, (k % 2 == 0) ? 32'h1 : 32'h0)); end
      tick();
    end
    total++; if (REC_VALID !== 1'b0) begin bad++; $display("FAIL fullpop_drained got=%b exp=0", REC_VALID); end
    REC_READY = 0;
  endtask
  task automatic test_stop_restart();
    WINDOW = 0; Q = 0; Q_t = 0; START = 1;
    tick();
    START = 0;
    for (int i = 0; i < 6; i++) begin
      Q_t = (i == 5) ? 32'h5 : 32'h0;
      Q = (i == 5) ? 2'b11 : 2'b00;
      STOP = (i == 5);
      tick();
    end
    STOP = 0;
    total++; if (DONE !== 1'b1 || EVT_CNT !== 16'd1) begin bad++; $display("FAIL stop_done got done=%b evt=%0d exp=1/1", DONE, EVT_CNT); end
    total++; if (REC_DATA !== rec(16'd5, 2'b11, 32'h5)) begin bad++; $display("FAIL stop_rec got=%h exp=%h", REC_DATA, rec(16'd5, 2'b11, 32'h5)); end
    START = 1;
    tick();
    START = 0;
    total++; if (BUSY !== 1'b1 || EVT_CNT !== 16'd0 || OVF_CNT !== 8'd0) begin bad++; $display("FAIL restart got busy=%b evt=%0d ovf=%0d exp=1/0/0", BUSY, EVT_CNT, OVF_CNT); end
    total++; if (REC_VALID !== 1'b1 || REC_DATA !== rec(16'd5, 2'b11, 32'h5)) begin bad++; $display("FAIL restart_keep got v=%b d=%h exp=1/%h", REC_VALID, REC_DATA, rec(16'd5, 2'b11, 32'h5)); end
    START = 1;
    tick();
    START = 0;
    total++; if (EVT_CNT !== 16'd0) begin bad++; $display("FAIL start_in_run got evt=%0d exp=0", EVT_CNT); end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      Q_t = (i % 2 == 0) ? 32'h0 : 32'h5;
      tick();
    end
    total++; if (EVT_CNT !== 16'd3 || BUSY !== 1'b1) begin bad++; $display("FAIL mid_pre got evt=%0d busy=%b exp=3/1", EVT_CNT, BUSY); end
`ifdef IFT_MONITOR_STICKY_EN
    total++; if (STICKY_T !== 32'h5) begin bad++; $display("FAIL mid_sticky got=%h exp=5", STICKY_T); end
`endif
    RST_N = 0;
    tick();
    RST_N = 1;
    total++; if (REC_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin bad++; $display("FAIL mid_reset got v=%b busy=%b done=%b exp=0/0/0", REC_VALID, BUSY, DONE); end
    total++; if (EVT_CNT !== 16'd0) begin bad++; $display("FAIL mid_reset_evt got=%0d exp=0", EVT_CNT); end
`ifdef IFT_MONITOR_STICKY_EN
    total++; if (STICKY_T !== 32'h0) begin bad++; $display("FAIL mid_reset_sticky got=%h exp=0", STICKY_T); end
`endif
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_stop_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
